// File: rtl/counter_cmd_scheduler.sv
// Command arbiter and decimal status reporter for the 0-9999 counter.
// Optional periodic reporting is enabled by defining CNT_AUTO_REPORT_EN.
module counter_cmd_scheduler #(
   parameter int CNT_W       = 14,
   parameter int CNT_MAX     = 9999,
   parameter int AUTO_PERIOD = 100_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_btn_enable,
   input  logic             i_btn_clear,
   input  logic             i_btn_mode,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_done,
   input  logic [CNT_W-1:0] i_counter,
   input  logic             i_tx_busy,
   output logic             o_tx_start,
   output logic [7:0]       o_tx_data,
   output logic             o_enable,
   output logic             o_clear,
   output logic             o_mode
);

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      SEND,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t state_q, state_d;
   logic enable_q, enable_d;
   logic mode_q, mode_d;
   logic clear_q, clear_d;
   logic tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [3:0][3:0] dig_q, dig_d;
   logic [1:0] pl_q, pl_d;
   logic [2:0] idx_q, idx_d;

   logic rx_r, rx_c, rx_m, rx_s;
   logic stat_req;
   logic [CNT_W-1:0] snap_sat;
   logic [CNT_W-1:0] weight;
   logic [7:0] cur_byte;

   assign rx_r = i_rx_done && (i_rx_data == 8'h52 || i_rx_data == 8'h72);
   assign rx_c = i_rx_done && (i_rx_data == 8'h43 || i_rx_data == 8'h63);
   assign rx_m = i_rx_done && (i_rx_data == 8'h4D || i_rx_data == 8'h6D);
   assign rx_s = i_rx_done && (i_rx_data == 8'h53 || i_rx_data == 8'h73);

   assign snap_sat = (i_counter > CNT_W'(CNT_MAX)) ?
                     CNT_W'(CNT_MAX) : i_counter;

`ifdef CNT_AUTO_REPORT_EN
   logic [31:0] per_q, per_d;
   logic auto_req;

   assign auto_req = enable_q && (per_q == 32'(AUTO_PERIOD - 1));

   always_comb begin
      per_d = per_q + 32'd1;
      if (!enable_q || auto_req) per_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) per_q <= '0;
      else     per_q <= per_d;
   end

   assign stat_req = rx_s || auto_req;
`else
   logic unused_period;
   assign unused_period = (AUTO_PERIOD != 0);
   assign stat_req = rx_s;
`endif

   always_comb begin
      case (pl_q)
         2'd0:    weight = CNT_W'(1000);
         2'd1:    weight = CNT_W'(100);
         default: weight = CNT_W'(10);
      endcase
   end

   always_comb begin
      case (idx_q)
         3'd4:    cur_byte = 8'h0D;
         3'd5:    cur_byte = 8'h0A;
         default: cur_byte = {4'h3, dig_q[idx_q[1:0]]};
      endcase
   end

   // Same-function sources are OR-ed first so coincident events toggle once
   always_comb begin
      enable_d = enable_q ^ (i_btn_enable || rx_r);
      mode_d   = mode_q ^ (i_btn_mode || rx_m);
      clear_d  = i_btn_clear || rx_c;
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      dig_d      = dig_q;
      pl_d       = pl_q;
      idx_d      = idx_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         IDLE: begin
            if (stat_req) begin
               rem_d   = snap_sat;
               dig_d   = '0;
               pl_d    = 2'd0;
               idx_d   = 3'd0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            if (rem_q >= weight) begin
               rem_d        = rem_q - weight;
               dig_d[pl_q]  = dig_q[pl_q] + 4'd1;
            end else if (pl_q == 2'd2) begin
               dig_d[3] = rem_q[3:0];
               state_d  = SEND;
            end else begin
               pl_d = pl_q + 2'd1;
            end
         end
         SEND: begin
            if (!i_tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = cur_byte;
               state_d    = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (i_tx_busy) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!i_tx_busy) begin
               if (idx_q == 3'd5) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         enable_q   <= 1'b0;
         mode_q     <= 1'b1;
         clear_q    <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         rem_q      <= '0;
         dig_q      <= '0;
         pl_q       <= 2'd0;
         idx_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         clear_q    <= clear_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         rem_q      <= rem_d;
         dig_q      <= dig_d;
         pl_q       <= pl_d;
         idx_q      <= idx_d;
      end
   end

   assign o_enable   = enable_q;
   assign o_mode     = mode_q;
   assign o_clear    = clear_q;
   assign o_tx_start = tx_start_q;
   assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_counter_cmd_scheduler.sv
// Randomized self-checking bench for counter_cmd_scheduler.
// A simple UART transmitter model records every started byte.
module tb_counter_cmd_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_btn_enable = 1'b0;
   logic        i_btn_clear = 1'b0;
   logic        i_btn_mode = 1'b0;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_done = 1'b0;
   logic [13:0] i_counter = '0;
   logic        i_tx_busy = 1'b0;
   logic        o_tx_start;
   logic [7:0]  o_tx_data;
   logic        o_enable;
   logic        o_clear;
   logic        o_mode;

   int checks = 0;
   int failures = 0;
   logic en_m = 1'b0;
   logic mode_m = 1'b1;
   logic [7:0] q_bytes[$];
   int busy_cnt = 0;

   counter_cmd_scheduler dut (
      .clk(clk),
      .rst(rst),
      .i_btn_enable(i_btn_enable),
      .i_btn_clear(i_btn_clear),
      .i_btn_mode(i_btn_mode),
      .i_rx_data(i_rx_data),
      .i_rx_done(i_rx_done),
      .i_counter(i_counter),
      .i_tx_busy(i_tx_busy),
      .o_tx_start(o_tx_start),
      .o_tx_data(o_tx_data),
      .o_enable(o_enable),
      .o_clear(o_clear),
      .o_mode(o_mode)
   );

   always #5 clk = ~clk;

   // Transmitter: busy for 20 clocks after each start
   always @(negedge clk) begin
      if (o_tx_start) begin
         q_bytes.push_back(o_tx_data);
         busy_cnt = 20;
         i_tx_busy = 1'b1;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) i_tx_busy = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      checks++;
      if ({o_enable, o_mode, o_clear, o_tx_start, o_tx_data} !==
          {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL %s en=%b mode=%b clr=%b st=%b d=%h want 0 1 0 0 00",
                  tag, o_enable, o_mode, o_clear, o_tx_start, o_tx_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      chk_reset_vals("reset_held");
      rst = 1'b0;
      tick();
      chk_reset_vals("reset_release");
      en_m = 1'b0;
      mode_m = 1'b1;
   endtask

   task automatic test_directed();
      i_btn_enable = 1'b1;
      tick();
      i_btn_enable = 1'b0;
      checks++;
      if (o_enable !== 1'b1) begin
         failures++;
         $display("FAIL btn_enable got=%b want=1", o_enable);
      end
      send_rx(8'h72);
      checks++;
      if (o_enable !== 1'b0) begin
         failures++;
         $display("FAIL uart_r got=%b want=0", o_enable);
      end
      i_btn_mode = 1'b1;
      i_rx_data = 8'h4D;
      i_rx_done = 1'b1;
      tick();
      i_btn_mode = 1'b0;
      i_rx_done = 1'b0;
      checks++;
      if (o_mode !== 1'b0) begin
         failures++;
         $display("FAIL mode_once got=%b want=0", o_mode);
      end
      send_rx(8'h6D);
      checks++;
      if (o_mode !== 1'b1) begin
         failures++;
         $display("FAIL uart_m got=%b want=1", o_mode);
      end
      i_btn_clear = 1'b1;
      i_rx_data = 8'h63;
      i_rx_done = 1'b1;
      tick();
      i_btn_clear = 1'b0;
      i_rx_done = 1'b0;
      checks++;
      if (o_clear !== 1'b1) begin
         failures++;
         $display("FAIL clear_hi got=%b want=1", o_clear);
      end
      tick();
      checks++;
      if (o_clear !== 1'b0) begin
         failures++;
         $display("FAIL clear_lo got=%b want=0", o_clear);
      end
      en_m = 1'b0;
      mode_m = 1'b1;
   endtask

   task automatic test_random_ctrl();
      logic [7:0] pick [7];
      logic clr_m;
      logic be, bc, bm, dn;
      logic [7:0] b;
      pick = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D, 8'h00};
      clr_m = 1'b0;
      for (int i = 0; i < 300; i++) begin
         checks++;
         if ({o_enable, o_mode, o_clear} !== {en_m, mode_m, clr_m}) begin
            failures++;
            $display("FAIL rand_ctrl i=%0d got=%b%b%b want=%b%b%b", i,
                     o_enable, o_mode, o_clear, en_m, mode_m, clr_m);
         end
         be = ($urandom_range(0, 3) == 0);
         bc = ($urandom_range(0, 3) == 0);
         bm = ($urandom_range(0, 3) == 0);
         dn = ($urandom_range(0, 1) == 1);
         b = pick[$urandom_range(0, 6)];
         if (b == 8'h00) b = 8'($urandom);
         if (b == 8'h53 || b == 8'h73) b = 8'h41;
         i_btn_enable = be;
         i_btn_clear = bc;
         i_btn_mode = bm;
         i_rx_data = b;
         i_rx_done = dn;
         if (be || (dn && (b == 8'h52 || b == 8'h72))) en_m = !en_m;
         if (bm || (dn && (b == 8'h4D || b == 8'h6D))) mode_m = !mode_m;
         clr_m = bc || (dn && (b == 8'h43 || b == 8'h63));
         tick();
      end
      i_btn_enable = 1'b0;
      i_btn_clear = 1'b0;
      i_btn_mode = 1'b0;
      i_rx_done = 1'b0;
      tick();
   endtask

   task automatic run_report(input int value, input bit change_mid,
                             input bit dup_s, input bit toggle_r,
                             input string tag);
      logic [7:0] exp_b [6];
      int v;
      int cnt;
      v = (value > 9999) ? 9999 : value;
      exp_b[0] = 8'(48 + v / 1000);
      exp_b[1] = 8'(48 + (v / 100) % 10);
      exp_b[2] = 8'(48 + (v / 10) % 10);
      exp_b[3] = 8'(48 + v % 10);
      exp_b[4] = 8'h0D;
      exp_b[5] = 8'h0A;
      q_bytes.delete();
      i_counter = 14'(value);
      send_rx(8'h73);
      if (change_mid) i_counter = 14'($urandom_range(0, 16383));
      if (dup_s) begin
         repeat (5) tick();
         send_rx(8'h53);
      end
      if (toggle_r) begin
         repeat (40) tick();
         send_rx(8'h52);
         en_m = !en_m;
         checks++;
         if (o_enable !== en_m) begin
            failures++;
            $display("FAIL %s_r_toggle got=%b want=%b", tag, o_enable, en_m);
         end
      end
      cnt = 0;
      while (q_bytes.size() < 6 && cnt < 2000) begin
         tick();
         cnt++;
      end
      repeat (100) tick();
      checks++;
      if (q_bytes.size() != 6) begin
         failures++;
         $display("FAIL %s_count got=%0d want=6", tag, q_bytes.size());
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= q_bytes.size()) begin
            failures++;
            $display("FAIL %s_byte%0d got=none want=%h", tag, i, exp_b[i]);
         end else if (q_bytes[i] !== exp_b[i]) begin
            failures++;
            $display("FAIL %s_byte%0d got=%h want=%h", tag, i,
                     q_bytes[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int cnt;
      int n;
      q_bytes.delete();
      i_counter = 14'd4321;
      send_rx(8'h73);
      cnt = 0;
      while (q_bytes.size() < 2 && cnt < 1000) begin
         tick();
         cnt++;
      end
      checks++;
      if (q_bytes.size() < 2) begin
         failures++;
         $display("FAIL mid_rst_wait got=%0d want=2", q_bytes.size());
      end
      rst = 1'b1;
      #1;
      chk_reset_vals("mid_rst");
      en_m = 1'b0;
      mode_m = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      n = q_bytes.size();
      repeat (200) tick();
      checks++;
      if (q_bytes.size() != n) begin
         failures++;
         $display("FAIL mid_rst_nostart got=%0d want=%0d",
                  q_bytes.size(), n);
      end
      run_report(int'($urandom_range(0, 16383)), 1'b0, 1'b0, 1'b0,
                 "after_rst");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_ctrl();
      run_report(1234, 1'b0, 1'b0, 1'b0, "rep1234");
      run_report(16383, 1'b0, 1'b0, 1'b0, "rep_sat");
      run_report(0, 1'b0, 1'b0, 1'b0, "rep_zero");
      run_report(9999, 1'b0, 1'b0, 1'b0, "rep_max");
      run_report(5678, 1'b1, 1'b0, 1'b0, "rep_mid");
      run_report(2468, 1'b0, 1'b1, 1'b0, "rep_dup");
      run_report(1357, 1'b0, 1'b0, 1'b1, "rep_run");
      for (int k = 0; k < 5; k++) begin
         run_report(int'($urandom_range(0, 16383)), 1'b1, 1'b0, 1'b0,
                    "rep_rand");
      end
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
